mem_port_arbiter: RTL

//  Shares one synchronous single-port word memory between the CPU instruction-fetch port
//  and the CPU data port (load/store with byte enables). Data requests normally win; a

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one synchronous single-port word memory between the CPU
//            instruction-fetch port and the CPU data (load/store) port. Data
//            requests normally win. A starvation counter forces a fetch grant
//            once fetch has lost STARVE_LIMIT consecutive cycles.
// Ports    : clk, reset (sync, active-high)
//            if_req/if_addr -> if_gnt, if_rvalid, if_rdata      (fetch port)
//            d_req/d_addr/d_byteen/d_wdata
//                           -> d_gnt, d_rvalid, d_rdata         (data port)
//            mem_addr/mem_re/mem_byteen/mem_wdata, mem_rdata    (memory side)
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int          ADDR_W       = 12,
    parameter logic [31:0] IMEM_BASE    = 32'h3000,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_byteen,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic [3:0]        mem_byteen,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] c_STARVE_LIMIT = 3'(STARVE_LIMIT);

    // Who owns the memory read data returning this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t      r_owner;
    owner_t      w_owner_next;
    logic [2:0]  r_starve;
    logic [2:0]  w_starve_next;
    logic        w_forced;
    logic        w_is_store;
    logic [31:0] w_if_off;
    logic        w_unused_bits;

    assign w_if_off   = if_addr - IMEM_BASE;
    assign w_forced   = (r_starve >= c_STARVE_LIMIT);
    assign w_is_store = (d_byteen != 4'b0000);

    // Byte offset and high address bits alias onto the same word by design.
    assign w_unused_bits = ^{w_if_off[31:ADDR_W+2], w_if_off[1:0],
                             d_addr[31:ADDR_W+2], d_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner  <= OWN_NONE;
            r_starve <= 3'd0;
        end else begin
            r_owner  <= w_owner_next;
            r_starve <= w_starve_next;
        end
    end

    always_comb begin
        if_gnt        = 1'b0;
        d_gnt         = 1'b0;
        mem_addr      = '0;
        mem_re        = 1'b0;
        mem_byteen    = 4'b0000;
        mem_wdata     = 32'd0;
        w_owner_next  = OWN_NONE;
        w_starve_next = 3'd0;

        // Grants are suppressed while reset is high so nothing reaches memory.
        if (!reset) begin
            if (w_forced && if_req) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end

        if (if_gnt) begin
            mem_addr     = w_if_off[ADDR_W+1:2];
            mem_re       = 1'b1;
            w_owner_next = OWN_IF;
        end else if (d_gnt) begin
            mem_addr = d_addr[ADDR_W+1:2];
            if (w_is_store) begin
                // Store completes at this edge; no response phase follows.
                mem_byteen = d_byteen;
                mem_wdata  = d_wdata;
            end else begin
                mem_re       = 1'b1;
                w_owner_next = OWN_D;
            end
        end

        // Saturating count of consecutive cycles a pending fetch was denied.
        if (if_req && !if_gnt) begin
            w_starve_next = w_forced ? c_STARVE_LIMIT : (r_starve + 3'd1);
        end
    end

    // Gating by reset discards a read still in flight when reset arrives.
    assign if_rvalid = !reset && (r_owner == OWN_IF);
    assign d_rvalid  = !reset && (r_owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    assign d_rdata   = d_rvalid  ? mem_rdata : 32'd0;

endmodule
`default_nettype wire
